cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the gate-level CPU core. It walks each instruction through fetch, decode, execute, memory and writeback. It drives the load/enable strobes of the dff-built PC, IR and register file, and handshakes with memory through a ready signal. A watchdog on memory waits converts a hung bus into a latched fault/halt.

Parameters:
WAIT_W, 4, width of the memory-wait counter; a wait times out after WAIT_LIMIT cycles.
WAIT_LIMIT, 15, number of consecutive not-ready cycles tolerated in FETCH or MEMORY (1..2^WAIT_W-1).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  level; permits starting/continuing execution
opcode  input  4  IR[15:12], stable from the cycle after ir_load
zero  input  1  ALU zero flag, used by BRZ in DECODE
mem_ready  input  1  memory completes the current access this cycle
mem_re  output  1  memory read request (FETCH, LOAD in MEMORY)
mem_we  output  1  memory write request (STORE in MEMORY)
ir_load  output  1  IR capture strobe
pc_inc  output  1  PC <= PC+1 strobe
pc_load  output  1  PC <= jump target strobe
alu_en  output  1  ALU result-register capture strobe
reg_we  output  1  register-file write strobe
instr_done  output  1  one-cycle pulse when an instruction retires
halted  output  1  in HALTED state
fault  output  1  sticky memory-timeout flag
state  output  3  current state encoding (debug)

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6. Code 7 is unreachable; if entered, go to IDLE next cycle.
- Reset: async. State=IDLE, wait counter=0, fault=0. All strobes 0 immediately, including mid-access.
- Outputs are combinational from state, opcode, zero and mem_ready. There is no output register.
- Opcode classes: 0x0 NOP; 0x1-0x7 ALU; 0x8 LD; 0x9 ST; 0xA JMP; 0xB BRZ; 0xF HLT; 0xC-0xE illegal, executed as NOP.
- IDLE: no strobes. Go to FETCH when run=1.
- FETCH: mem_re=1.
  - mem_ready=1: ir_load=1 that cycle, go to DECODE, clear counter.
  - Otherwise: counter+1.
- DECODE: exactly 1 cycle.
  - HLT: no PC strobe, instr_done=1, go to HALTED.
  - JMP: pc_load=1, instr_done=1.
  - BRZ: pc_load=zero, pc_inc=~zero, instr_done=1.
  - NOP/illegal: pc_inc=1, instr_done=1.
  - ALU/LD/ST: pc_inc=1, go to EXECUTE.
  - For all retired instructions except HLT, next state is FETCH if run=1, else IDLE.
- EXECUTE: alu_en=1 for 1 cycle. ALU goes to WRITEBACK; LD/ST go to MEMORY.
- MEMORY: LD drives mem_re=1; ST drives mem_we=1.
  - mem_ready=1 with LD: go to WRITEBACK.
  - mem_ready=1 with ST: instr_done=1, go to FETCH/IDLE by run.
  - Otherwise: counter+1.
- WRITEBACK: reg_we=1, instr_done=1, then FETCH/IDLE by run.
- run is sampled only at retirement. Dropping run mid-instruction never aborts it.
- Wait watchdog: the counter counts consecutive not-ready cycles in FETCH/MEMORY and saturates at 2^WAIT_W-1.
  - If the counter equals WAIT_LIMIT and mem_ready=0, set fault=1 and go to HALTED. All requests drop the next cycle.
  - mem_ready arriving in the same cycle the limit is reached takes priority, so no fault is raised.
- HALTED: halted=1, all strobes 0. Exit only via rst; run is ignored.
- Invariants, every cycle:
  - At most one of pc_inc/pc_load.
  - mem_re and mem_we never both set.
  - reg_we and mem_we never both set.
- Cycles per instruction with zero-wait memory (mem_ready=1 on first request):
  - NOP/JMP/BRZ/HLT: 2 cycles.
  - ST: 4 cycles.
  - ALU: 4 cycles.
  - LD: 5 cycles.

Test Plan:
- rst=1, then release with run=1 and an always-ready memory streaming ALU op 0x3. Expect state sequence 0,1,2,3,5,1; ir_load, pc_inc, alu_en and reg_we each pulse once per instruction; instr_done every 4 cycles.
- LD with mem_ready delayed 3 cycles in MEMORY. Expect mem_re held 4 cycles, then WRITEBACK with reg_we=1, total 8 cycles, fault=0.
- BRZ with zero=1, then BRZ with zero=0. Expect pc_load=1/pc_inc=0, then pc_inc=1/pc_load=0; each retires in 2 cycles.
- mem_ready held 0 in FETCH with WAIT_LIMIT=15. Expect mem_re for 16 cycles, then halted=1, fault=1, state=6, mem_re=0. Also mem_ready=1 exactly on the 16th cycle: expect no fault.
- HLT opcode. Expect halted=1 two cycles after fetch completes. Toggling run has no effect; rst returns state=0, fault=0.
- Drop run during EXECUTE of an ST. Expect the store to complete (mem_we until ready), then IDLE. Assert rst mid-MEMORY: mem_we falls immediately (asynchronously), state=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the gate-level CPU core.
// Strobes are decoded combinationally from state; a memory-wait watchdog latches a fault and halts.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for run, no strobes
// FETCH     | instruction read, ir_load when memory is ready
// DECODE    | one cycle; retires NOP/JMP/BRZ/HLT/illegal, else advances PC
// EXECUTE   | one ALU capture cycle
// MEMORY    | LD read or ST write, held until mem_ready
// WRITEBACK | register-file write, retires ALU and LD
// HALTED    | terminal until rst; halted=1 and no strobes
module cpu_sequencer #(
   parameter int WAIT_W     = 4,
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_re,
   output logic       mem_we,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       alu_en,
   output logic       reg_we,
   output logic       instr_done,
   output logic       halted,
   output logic       fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_HALTED    = 3'd6
   } state_t;

   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_LIMIT);

   state_t            st;
   logic [WAIT_W-1:0] wait_left;
   logic              fault_q;

   logic is_alu, is_ld, is_st, is_jmp, is_brz, is_hlt;
   logic mem_wait, timeout;
   state_t retire_next;

   assign is_alu = (opcode >= 4'h1) && (opcode <= 4'h7);
   assign is_ld  = (opcode == 4'h8);
   assign is_st  = (opcode == 4'h9);
   assign is_jmp = (opcode == 4'hA);
   assign is_brz = (opcode == 4'hB);
   assign is_hlt = (opcode == 4'hF);

   // Watchdog is a down-counter reloaded on every completed access; terminal count is zero.
   assign mem_wait    = (st == ST_FETCH) || ((st == ST_MEMORY) && (is_ld || is_st));
   assign timeout     = mem_wait && !mem_ready && (wait_left == '0);
   assign retire_next = run ? ST_FETCH : ST_IDLE;

   assign state  = st;
   assign fault  = fault_q;
   assign halted = (st == ST_HALTED);

   always_comb begin
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      alu_en     = 1'b0;
      reg_we     = 1'b0;
      instr_done = 1'b0;
      case (st)
         ST_FETCH: begin
            mem_re  = 1'b1;
            ir_load = mem_ready;
         end
         ST_DECODE: begin
            if (is_hlt) begin
               instr_done = 1'b1;
            end else if (is_jmp) begin
               pc_load    = 1'b1;
               instr_done = 1'b1;
            end else if (is_brz) begin
               pc_load    = zero;
               pc_inc     = ~zero;
               instr_done = 1'b1;
            end else begin
               pc_inc     = 1'b1;
               instr_done = !(is_alu || is_ld || is_st);
            end
         end
         ST_EXECUTE:   alu_en = 1'b1;
         ST_MEMORY: begin
            mem_re     = is_ld;
            mem_we     = is_st;
            instr_done = (is_st && mem_ready) || !(is_ld || is_st);
         end
         ST_WRITEBACK: begin
            reg_we     = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= ST_IDLE;
         wait_left <= WAIT_INIT;
         fault_q   <= 1'b0;
      end else begin
         if (mem_wait) begin
            if (mem_ready)
               wait_left <= WAIT_INIT;
            else if (wait_left != '0)
               wait_left <= wait_left - 1'b1;
         end
         if (timeout) begin
            fault_q <= 1'b1;
            st      <= ST_HALTED;
         end else begin
            case (st)
               ST_IDLE:      if (run) st <= ST_FETCH;
               ST_FETCH:     if (mem_ready) st <= ST_DECODE;
               ST_DECODE: begin
                  if (is_hlt)
                     st <= ST_HALTED;
                  else if (is_alu || is_ld || is_st)
                     st <= ST_EXECUTE;
                  else
                     st <= retire_next;
               end
               ST_EXECUTE:   st <= (is_ld || is_st) ? ST_MEMORY : ST_WRITEBACK;
               ST_MEMORY: begin
                  if (is_ld) begin
                     if (mem_ready) st <= ST_WRITEBACK;
                  end else if (is_st) begin
                     if (mem_ready) st <= retire_next;
                  end else begin
                     st <= retire_next;
                  end
               end
               ST_WRITEBACK: st <= retire_next;
               ST_HALTED:    st <= ST_HALTED;
               default:      st <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle state and strobe vectors against hand-derived values.
module tb_cpu_sequencer;

   logic       clk;
   logic       rst;
   logic       run;
   logic [3:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_re, mem_we, ir_load, pc_inc, pc_load, alu_en, reg_we;
   logic       instr_done, halted, fault;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   localparam logic [9:0] NONE = 10'h000;
   localparam logic [9:0] RE   = 10'h200;
   localparam logic [9:0] WE   = 10'h100;
   localparam logic [9:0] IR   = 10'h080;
   localparam logic [9:0] PCI  = 10'h040;
   localparam logic [9:0] PCL  = 10'h020;
   localparam logic [9:0] ALU  = 10'h010;
   localparam logic [9:0] REG  = 10'h008;
   localparam logic [9:0] DONE = 10'h004;
   localparam logic [9:0] HLT  = 10'h002;
   localparam logic [9:0] FLT  = 10'h001;

   cpu_sequencer #(.WAIT_W(4), .WAIT_LIMIT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .ir_load    (ir_load),
      .pc_inc     (pc_inc),
      .pc_load    (pc_load),
      .alu_en     (alu_en),
      .reg_we     (reg_we),
      .instr_done (instr_done),
      .halted     (halted),
      .fault      (fault),
      .state      (state)
   );

   logic [12:0] obs;
   assign obs = {state, mem_re, mem_we, ir_load, pc_inc, pc_load, alu_en, reg_we,
                 instr_done, halted, fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed state=%0d strobes=%b expected state=%0d strobes=%b",
                tag, got[12:10], got[9:0], exp[12:10], exp[9:0]);
      end
   endtask

   // Inputs are set just after a rising edge; outputs are checked 1ns later, then advance one cycle.
   task automatic cyc(input string tag, input logic [2:0] s, input logic [9:0] strb);
      #1;
      chk(tag, obs, {s, strb});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Streaming ALU op 0x3 with always-ready memory
      run = 1'b1; mem_ready = 1'b1; opcode = 4'h3;
      cyc("reset", 3'd0, NONE);
      rst = 1'b0;
      cyc("alu_idle", 3'd0, NONE);
      for (int i = 0; i < 2; i++) begin
         cyc("alu_fetch", 3'd1, RE | IR);
         cyc("alu_decode", 3'd2, PCI);
         cyc("alu_execute", 3'd3, ALU);
         cyc("alu_wb", 3'd5, REG | DONE);
      end

      // LD with three not-ready cycles in MEMORY
      opcode = 4'h8;
      cyc("ld_fetch", 3'd1, RE | IR);
      cyc("ld_decode", 3'd2, PCI);
      cyc("ld_execute", 3'd3, ALU);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("ld_mem_wait", 3'd4, RE);
      mem_ready = 1'b1;
      cyc("ld_mem_ready", 3'd4, RE);
      cyc("ld_wb", 3'd5, REG | DONE);

      // BRZ taken/not taken, JMP, illegal opcode
      opcode = 4'hB; zero = 1'b1;
      cyc("brz1_fetch", 3'd1, RE | IR);
      cyc("brz_taken", 3'd2, PCL | DONE);
      zero = 1'b0;
      cyc("brz0_fetch", 3'd1, RE | IR);
      cyc("brz_not_taken", 3'd2, PCI | DONE);
      opcode = 4'hA; zero = 1'b1;
      cyc("jmp_fetch", 3'd1, RE | IR);
      cyc("jmp_decode", 3'd2, PCL | DONE);
      opcode = 4'hD;
      cyc("ill_fetch", 3'd1, RE | IR);
      cyc("ill_decode", 3'd2, PCI | DONE);

      // Ready arrives on the limit cycle: no fault
      opcode = 4'h0; mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) cyc("edge_fetch_wait", 3'd1, RE);
      mem_ready = 1'b1;
      cyc("edge_fetch_ready", 3'd1, RE | IR);
      cyc("edge_nop_decode", 3'd2, PCI | DONE);

      // Fetch never ready: timeout after 16 request cycles
      mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 3'd1, RE);
      cyc("to_halted", 3'd6, HLT | FLT);
      run = 1'b0;
      cyc("to_run_low", 3'd6, HLT | FLT);
      run = 1'b1; mem_ready = 1'b1;
      cyc("to_run_high", 3'd6, HLT | FLT);
      rst = 1'b1;
      cyc("to_reset", 3'd0, NONE);
      rst = 1'b0;

      // HLT
      opcode = 4'hF;
      cyc("hlt_idle", 3'd0, NONE);
      cyc("hlt_fetch", 3'd1, RE | IR);
      cyc("hlt_decode", 3'd2, DONE);
      cyc("hlt_halted", 3'd6, HLT);
      run = 1'b0;
      cyc("hlt_run_low", 3'd6, HLT);
      run = 1'b1;
      cyc("hlt_run_high", 3'd6, HLT);
      rst = 1'b1;
      cyc("hlt_reset", 3'd0, NONE);
      rst = 1'b0;

      // ST with run dropped during EXECUTE completes, then idles
      opcode = 4'h9;
      cyc("st_idle", 3'd0, NONE);
      cyc("st_fetch", 3'd1, RE | IR);
      cyc("st_decode", 3'd2, PCI);
      run = 1'b0;
      cyc("st_execute", 3'd3, ALU);
      mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) cyc("st_mem_wait", 3'd4, WE);
      mem_ready = 1'b1;
      cyc("st_mem_ready", 3'd4, WE | DONE);
      cyc("st_to_idle", 3'd0, NONE);
      cyc("st_stay_idle", 3'd0, NONE);

      // Asynchronous reset in the middle of a store
      run = 1'b1;
      cyc("st2_idle", 3'd0, NONE);
      cyc("st2_fetch", 3'd1, RE | IR);
      cyc("st2_decode", 3'd2, PCI);
      cyc("st2_execute", 3'd3, ALU);
      mem_ready = 1'b0;
      #1;
      chk("st2_mem_wait", obs, {3'd4, WE});
      rst = 1'b1;
      #1;
      chk("st2_async_reset", obs, {3'd0, NONE});
      @(posedge clk);
      #1;
      rst = 1'b0; run = 1'b0;
      cyc("st2_after_reset", 3'd0, NONE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
